// File: rtl/imips_pkg.sv
// rtl/imips_pkg.sv - shared fetch types and widths
package imips_pkg;

    localparam int PC_W_DEFAULT = 10;
    localparam int BOFF_W       = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_IN = 2'd1,
        HALT    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC selection (jump > branch > sequential)
module pc_next_calc
    import imips_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0]   pc,
    input  logic              jump,
    input  logic              branch,
    input  logic              cond,
    input  logic              flag,
    input  logic [PC_W-1:0]   jtarget,
    input  logic [BOFF_W-1:0] boff,
    output logic [PC_W-1:0]   pc_inc,
    output logic [PC_W-1:0]   npc
);

    // Arithmetic runs at the wider of PC and offset widths, then truncates so it wraps mod 2^PC_W
    localparam int SW = (PC_W > BOFF_W) ? PC_W : BOFF_W;

    logic [SW-1:0] pc_ext;
    logic [SW-1:0] boff_ext;
    logic [SW-1:0] btarget;
    logic          taken;

    // Pick the next PC: taken jump, then taken branch, else fall through
    always_comb begin
        pc_ext   = SW'(pc);
        boff_ext = SW'($signed(boff));
        btarget  = pc_ext + boff_ext + SW'(1);
        taken    = (jump | branch) & (~cond | flag);
        pc_inc   = pc + PC_W'(1);
        if (taken && jump) begin
            npc = jtarget;
        end else if (taken) begin
            npc = btarget[PC_W-1:0];
        end else begin
            npc = pc_inc;
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - PC register and RUN/WAIT_IN/HALT fetch FSM; optional FETCH_BREAKPOINT_EN
module fetch_pc
    import imips_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump,
    input  logic              branch,
    input  logic              cond,
    input  logic              flag,
    input  logic              sleep,
    input  logic              inop,
    input  logic [PC_W-1:0]   jtarget,
    input  logic [BOFF_W-1:0] boff,
    input  logic              in_valid,
    input  logic              resume,
`ifdef FETCH_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
`endif
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_link,
    output logic              in_ack,
    output logic              stall,
    output logic              halted
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] npc;
    logic            in_ack_c;
    logic            bp_hit;

`ifdef FETCH_BREAKPOINT_EN
    assign bp_hit = bp_en && (pc == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    pc_next_calc #(.PC_W(PC_W)) u_next (
        .pc      (pc),
        .jump    (jump),
        .branch  (branch),
        .cond    (cond),
        .flag    (flag),
        .jtarget (jtarget),
        .boff    (boff),
        .pc_inc  (pc_inc),
        .npc     (npc)
    );

    // State and PC registers; reset abandons any wait or halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc      <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
        end
    end

    // Next state, next PC and the input-consume strobe; decode only matters in RUN
    always_comb begin
        state_d  = state_q;
        pc_d     = pc;
        in_ack_c = 1'b0;
        case (state_q)
            RUN: begin
                if (sleep || bp_hit) begin
                    state_d = HALT;
                end else if (inop && !in_valid) begin
                    state_d = WAIT_IN;
                end else if (inop) begin
                    in_ack_c = 1'b1;
                    pc_d     = pc_inc;
                end else begin
                    pc_d = npc;
                end
            end
            WAIT_IN: begin
                if (in_valid) begin
                    in_ack_c = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = RUN;
                end
            end
            HALT: begin
                if (resume) begin
                    pc_d    = pc_inc;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Reset masks the strobe so an abandoned wait never acknowledges
    assign in_ack  = in_ack_c & ~rst;
    assign pc_link = pc_inc;
    assign stall   = (state_q != RUN);
    assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - directed bench with behavioural model for fetch_pc
module tb_fetch_pc;

    localparam int PC_W = 10;
    localparam int MOD  = 1 << PC_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            jump = 1'b0, branch = 1'b0, cond = 1'b0, flag = 1'b0;
    logic            sleep = 1'b0, inop = 1'b0, in_valid = 1'b0, resume = 1'b0;
    logic [PC_W-1:0] jtarget = '0;
    logic [15:0]     boff = '0;
`ifdef FETCH_BREAKPOINT_EN
    logic            bp_en = 1'b0;
    logic [PC_W-1:0] bp_addr = '0;
`endif
    logic [PC_W-1:0] pc, pc_link;
    logic            in_ack, stall, halted;

    int vectors = 0;
    int miscompares = 0;

    // model: mode 0 = running, 1 = waiting for input, 2 = halted
    int m_pc = 0;
    int m_mode = 0;

    fetch_pc #(.PC_W(PC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .jump     (jump),
        .branch   (branch),
        .cond     (cond),
        .flag     (flag),
        .sleep    (sleep),
        .inop     (inop),
        .jtarget  (jtarget),
        .boff     (boff),
        .in_valid (in_valid),
        .resume   (resume),
`ifdef FETCH_BREAKPOINT_EN
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
`endif
        .pc       (pc),
        .pc_link  (pc_link),
        .in_ack   (in_ack),
        .stall    (stall),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    function automatic int wrap(input int x);
        return ((x % MOD) + MOD) % MOD;
    endfunction

    function automatic bit bp_now();
`ifdef FETCH_BREAKPOINT_EN
        return bp_en && (m_pc == int'(bp_addr));
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ack();
        if (rst) return 1'b0;
        if (m_mode == 1) return in_valid;
        if (m_mode == 0) return !sleep && !bp_now() && inop && in_valid;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // behavioural model of the fetch rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc   <= 0;
            m_mode <= 0;
        end else if (m_mode == 0) begin
            if (sleep || bp_now()) begin
                m_mode <= 2;
            end else if (inop) begin
                if (in_valid) m_pc <= wrap(m_pc + 1);
                else          m_mode <= 1;
            end else if ((jump || branch) && (!cond || flag)) begin
                if (jump) m_pc <= int'(jtarget);
                else      m_pc <= wrap(m_pc + 1 + int'($signed(boff)));
            end else begin
                m_pc <= wrap(m_pc + 1);
            end
        end else if (m_mode == 1) begin
            if (in_valid) begin
                m_pc   <= wrap(m_pc + 1);
                m_mode <= 0;
            end
        end else begin
            if (resume) begin
                m_pc   <= wrap(m_pc + 1);
                m_mode <= 0;
            end
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("pc", int'(pc), m_pc);
        chk("pc_link", int'(pc_link), wrap(m_pc + 1));
        chk("stall", int'(stall), int'(m_mode != 0));
        chk("halted", int'(halted), int'(m_mode == 2));
        chk("in_ack", int'(in_ack), int'(exp_ack()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        jump = 0; branch = 0; cond = 0; flag = 0;
        sleep = 0; inop = 0; in_valid = 0; resume = 0;
        boff = '0;
    endtask

    task automatic go(input int addr);
        clr();
        jump = 1;
        jtarget = PC_W'(addr);
        tick();
        clr();
    endtask

    initial begin
        repeat (2) tick();
        chk("lit_reset_pc", int'(pc), 0);
        chk("lit_reset_stall", int'(stall), 0);
        chk("lit_reset_halted", int'(halted), 0);
        rst = 0;

        // sequential fetch from reset
        for (int i = 0; i <= 5; i++) begin
            chk("lit_seq_pc", int'(pc), i);
            if (i < 5) tick();
        end

        // conditional branch not taken / taken, offset -3
        go(20);
        branch = 1; cond = 1; flag = 0; boff = 16'hFFFD;
        tick();
        chk("lit_br_nt", int'(pc), 21);
        go(20);
        branch = 1; cond = 1; flag = 1; boff = 16'hFFFD;
        tick();
        chk("lit_br_t", int'(pc), 18);

        // conditional jump not taken falls through
        go(40);
        jump = 1; cond = 1; flag = 0; jtarget = 10'd200;
        tick();
        chk("lit_jmp_nt", int'(pc), 41);

        // wrap at top of address space; jump beats branch
        go(1023);
        tick();
        chk("lit_wrap", int'(pc), 0);
        jump = 1; branch = 1; jtarget = 10'd100; boff = 16'd5;
        tick();
        chk("lit_jmp_prio", int'(pc), 100);
        go(1020);
        branch = 1; boff = 16'd10;
        tick();
        chk("lit_br_wrap_up", int'(pc), 7);
        go(0);
        branch = 1; boff = 16'hFFFB;
        tick();
        chk("lit_br_wrap_dn", int'(pc), 1020);

        // wait for input; decode ignored while waiting
        go(7);
        inop = 1;
        tick();
        jump = 1; jtarget = 10'd500;
        for (int i = 0; i < 4; i++) begin
            chk("lit_wait_pc", int'(pc), 7);
            chk("lit_wait_stall", int'(stall), 1);
            tick();
        end
        clr();
        in_valid = 1;
        #1;
        chk("lit_wait_ack", int'(in_ack), 1);
        tick();
        in_valid = 0;
        chk("lit_wait_pc8", int'(pc), 8);
        chk("lit_wait_ack_off", int'(in_ack), 0);

        // input already valid in RUN
        inop = 1; in_valid = 1;
        #1;
        chk("lit_run_ack", int'(in_ack), 1);
        tick();
        clr();
        chk("lit_run_ack_pc", int'(pc), 9);

        // sleep beats everything; halt holds; reset leaves halt
        sleep = 1; jump = 1; jtarget = 10'd300; inop = 1; in_valid = 1;
        tick();
        clr();
        jump = 1;
        for (int i = 0; i < 3; i++) begin
            chk("lit_halt_pc", int'(pc), 9);
            chk("lit_halted", int'(halted), 1);
            tick();
        end
        clr();
        rst = 1;
        #1;
        chk("lit_async_rst_pc", int'(pc), 0);
        chk("lit_async_rst_halt", int'(halted), 0);
        tick();
        rst = 0;
        go(9);
        sleep = 1;
        tick();
        clr();
        tick();
        resume = 1;
        tick();
        clr();
        chk("lit_resume_pc", int'(pc), 10);
        chk("lit_resume_run", int'(stall), 0);

        // reset while waiting abandons the input without an ack
        go(30);
        inop = 1;
        tick();
        clr();
        rst = 1;
        in_valid = 1;
        #1;
        chk("lit_rst_wait_ack", int'(in_ack), 0);
        chk("lit_rst_wait_pc", int'(pc), 0);
        tick();
        in_valid = 0;
        rst = 0;
        tick();

`ifdef FETCH_BREAKPOINT_EN
        // breakpoint at 3, resume continues at 4
        rst = 1;
        tick();
        bp_en = 1;
        bp_addr = 10'd3;
        rst = 0;
        repeat (4) tick();
        chk("lit_bp_pc", int'(pc), 3);
        chk("lit_bp_halted", int'(halted), 1);
        tick();
        resume = 1;
        tick();
        clr();
        chk("lit_bp_resume", int'(pc), 4);
        bp_en = 0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter PC_W, default 10, instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 jump  input  1  absolute-jump request from control-unit decode.
REQ-006 branch  input  1  relative-branch request from control-unit decode.
REQ-007 cond  input  1  jump/branch qualified by flag when high.
REQ-008 flag  input  1  comparison result of the current instruction's condition register.
REQ-009 sleep  input  1  STOP decoded; halt the core.
REQ-010 inop  input  1  IN instruction decoded; requires external input.
REQ-011 jtarget  input  PC_W  absolute jump target.
REQ-012 boff  input  16  signed two's-complement branch offset, in words.
REQ-013 in_valid  input  1  external input word available.
REQ-014 resume  input  1  external request to leave HALT.
REQ-015 pc  output  PC_W  address of the current instruction.
REQ-016 pc_link  output  PC_W  pc+1 (mod 2^PC_W), the return address for jal/bal.
REQ-017 in_ack  output  1  one-cycle pulse consuming the external input word.
REQ-018 stall  output  1  high while not in RUN; downstream register/memory writes SHALL be gated by it.
REQ-019 halted  output  1  high in HALT.

Function
REQ-020 FSM states are RUN, WAIT_IN, and HALT.
REQ-021 taken = (jump | branch) & (~cond | flag).
REQ-022 Next-PC rules, in priority order:
- jump taken -> jtarget.
- branch taken -> pc+1+sext(boff), truncated to PC_W.
- otherwise -> pc+1.
REQ-023 Jump SHALL win when jump and branch are both high.
REQ-024 pc+1 and branch arithmetic SHALL wrap modulo 2^PC_W, with no error flag.
REQ-025 RUN transitions:
- sleep high -> HALT, pc holds; sleep has priority over all other inputs.
- else inop high with in_valid low -> WAIT_IN, pc holds.
- else inop high with in_valid high -> in_ack=1 the same cycle, pc <= pc+1, stay in RUN.
- else -> pc <= next-PC, stay in RUN.
REQ-026 WAIT_IN: in_valid high -> in_ack=1 for exactly that cycle, pc <= pc+1, go to RUN; otherwise hold.
REQ-027 HALT: resume high -> pc <= pc+1, go to RUN; otherwise hold indefinitely.
REQ-028 Decode inputs SHALL be ignored outside RUN.
REQ-029 in_ack SHALL be combinational from state and in_valid, never high outside the consuming cycle.
REQ-030 PC update latency is one cycle; pc is always a registered output.

Reset
REQ-031 rst high -> asynchronously: pc=RESET_PC, state=RUN, in_ack=0, stall=0, halted=0.
REQ-032 Reset asserted in WAIT_IN or HALT SHALL abandon the operation with no in_ack pulse.

Configuration
REQ-033 Macro FETCH_BREAKPOINT_EN:
- When defined, adds ports bp_en (in, 1) and bp_addr (in, PC_W).
- In RUN with bp_en=1 and pc==bp_addr, the block SHALL enter HALT with pc held; resume continues with pc+1.
- Precedence: sleep > breakpoint > inop > next-PC.
REQ-034 Without the macro, the ports and the compare logic are absent; behaviour is per REQ-020..032.

Structure
REQ-035 Shared package imips_pkg SHALL hold:
- state enum fetch_state_t {RUN, WAIT_IN, HALT};
- default PC_W;
- localparam BOFF_W=16.
REQ-036 Next-PC selection SHALL be the combinational sub-module pc_next_calc; fetch_pc holds the FSM and PC register.

Verification
REQ-037 The bench SHALL cover these scenarios:
- Reset, then 5 cycles with no decode -> pc 0,1,2,3,4,5.
- pc=20, branch=1, cond=1, flag=0, boff=-3 -> pc=21; repeat with flag=1 -> pc=18.
- pc=1023 (PC_W=10), no decode -> pc=0; jump=1, branch=1, jtarget=100, boff=5 -> pc=100.
- pc=7, inop=1, in_valid=0 for 4 cycles -> pc stays 7, stall=1; in_valid=1 -> single in_ack pulse, next pc=8.
- pc=9, sleep=1 -> HALT, halted=1, pc=9; rst pulse -> pc=0, RUN; repeat HALT then resume=1 -> pc=10.
- With FETCH_BREAKPOINT_EN: bp_en=1, bp_addr=3 -> HALT at pc=3; resume -> pc=4.
